// File: rtl/fifo_align_rd_stream.sv
// Read-side FIFO consumer: pops words into a 2-entry registered skid buffer
// and presents them downstream as a valid/ready stream with a delivered-word counter.
module fifo_align_rd_stream #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_fifo_empty,
    input  logic [DATA_W-1:0] i_fifo_data,
    output logic              o_fifo_advance,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    input  logic              i_ready,
    input  logic              i_cnt_clr,
    output logic [1:0]        o_level,
    output logic [CNT_W-1:0]  o_cnt
);

    typedef enum logic [1:0] {
        LVL_EMPTY = 2'd0,
        LVL_ONE   = 2'd1,
        LVL_TWO   = 2'd2
    } level_e;

    level_e            level_q, level_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic busy;
    logic full;
    logic pop;
    logic take;

    assign busy = (level_q != LVL_EMPTY);
    assign full = (level_q == LVL_TWO);

    // Pop request uses registered occupancy only, never the downstream ready;
    // rst_n gating keeps it low while the buffer is held in reset.
    assign pop  = rst_n & ~i_fifo_empty & ~full;
    assign take = busy & i_ready;

    always_comb begin
        level_d = level_q;
        head_d  = head_q;
        tail_d  = tail_q;
        unique case (level_q)
            LVL_EMPTY: begin
                if (pop) begin
                    head_d  = i_fifo_data;
                    level_d = LVL_ONE;
                end
            end
            LVL_ONE: begin
                if (pop && !take) begin
                    tail_d  = i_fifo_data;
                    level_d = LVL_TWO;
                end else if (pop && take) begin
                    head_d  = i_fifo_data;
                end else if (take) begin
                    level_d = LVL_EMPTY;
                end
            end
            LVL_TWO: begin
                if (take) begin
                    head_d  = tail_q;
                    level_d = LVL_ONE;
                end
            end
            default: begin
                level_d = LVL_EMPTY;
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (i_cnt_clr) begin
            cnt_d = '0;
        end else if (take) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= LVL_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
        end else begin
            level_q <= level_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_fifo_advance = pop;
    assign o_valid        = busy;
    assign o_data         = head_q;
    assign o_level        = level_q;
    assign o_cnt          = cnt_q;

endmodule

// File: tb/tb_fifo_align_rd_stream.sv
// Bench for fifo_align_rd_stream: FIFO model feeds the DUT, a scoreboard
// queue holds expected words and a negedge monitor compares deliveries.
module tb_fifo_align_rd_stream;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic          i_fifo_empty;
    logic [DW-1:0] i_fifo_data;
    logic          o_fifo_advance;
    logic          o_valid;
    logic [DW-1:0] o_data;
    logic          i_ready;
    logic          i_cnt_clr;
    logic [1:0]    o_level;
    logic [CW-1:0] o_cnt;

    fifo_align_rd_stream #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_fifo_empty   (i_fifo_empty),
        .i_fifo_data    (i_fifo_data),
        .o_fifo_advance (o_fifo_advance),
        .o_valid        (o_valid),
        .o_data         (o_data),
        .i_ready        (i_ready),
        .i_cnt_clr      (i_cnt_clr),
        .o_level        (o_level),
        .o_cnt          (o_cnt)
    );

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    logic [CW-1:0] cnt_m;
    bit            adv_s;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive_fifo(input bit gap);
        i_fifo_empty = (fifo_q.size() == 0) || gap;
        i_fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endtask

    // One cycle: apply the pop seen last cycle, drive new inputs,
    // return mid-cycle so outputs can be checked before the negedge.
    task automatic step(input bit rdy, input bit gap, input bit clr);
        @(posedge clk);
        #1;
        if (adv_s && fifo_q.size() != 0) void'(fifo_q.pop_front());
        i_ready   = rdy;
        i_cnt_clr = clr;
        drive_fifo(gap);
        #1;
    endtask

    task automatic load(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(base + DW'(i));
            exp_q.push_back(base + DW'(i));
        end
    endtask

    task automatic drain(input int lim, input bit alt, input bit gaps,
                         input string name);
        bit done;
        done = 1'b0;
        for (int k = 0; k < lim; k++) begin
            if (exp_q.size() == 0 && o_level == 2'd0 && fifo_q.size() == 0) begin
                done = 1'b1;
                break;
            end
            step(alt ? k[0] : 1'b1,
                 gaps ? ($urandom_range(0, 2) == 0) : 1'b0, 1'b0);
        end
        chk(name, {31'd0, done}, 32'd1);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            cnt_m = '0;
            adv_s = 1'b0;
        end else begin
            adv_s = o_fifo_advance;
            chk("mon_cnt", {28'd0, o_cnt}, {28'd0, cnt_m});
            chk("mon_lvl_max", {31'd0, (o_level <= 2'd2)}, 32'd1);
            chk("mon_valid_lvl", {31'd0, o_valid}, {31'd0, (o_level != 2'd0)});
            if (o_fifo_advance)
                chk("mon_adv_empty", {31'd0, i_fifo_empty}, 32'd0);
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0)
                    chk("sb_extra", o_data, 32'hdead_beef);
                else
                    chk("sb_data", o_data, exp_q.pop_front());
            end
            if (i_cnt_clr) cnt_m = '0;
            else if (o_valid && i_ready) cnt_m = cnt_m + 1'b1;
        end
    end

    initial begin
        rst_n        = 1'b0;
        i_ready      = 1'b0;
        i_cnt_clr    = 1'b0;
        i_fifo_empty = 1'b1;
        i_fifo_data  = '0;
        cnt_m        = '0;
        adv_s        = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_data", o_data, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: idle with empty FIFO
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b0);
            chk("t1_adv", {31'd0, o_fifo_advance}, 32'd0);
            chk("t1_valid", {31'd0, o_valid}, 32'd0);
            chk("t1_level", {30'd0, o_level}, 32'd0);
            chk("t1_cnt", {28'd0, o_cnt}, 32'd0);
        end

        // 2: 8 words streamed with ready held high
        load(32'h10, 8);
        step(1'b1, 1'b0, 1'b0);
        chk("t2_adv0", {31'd0, o_fifo_advance}, 32'd1);
        chk("t2_valid0", {31'd0, o_valid}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 1'b0);
            chk("t2_valid", {31'd0, o_valid}, 32'd1);
            chk("t2_data", o_data, 32'h10 + 32'(i));
            chk("t2_adv", {31'd0, o_fifo_advance}, {31'd0, (i < 7)});
        end
        step(1'b1, 1'b0, 1'b0);
        chk("t2_level", {30'd0, o_level}, 32'd0);
        chk("t2_cnt", {28'd0, o_cnt}, 32'd8);

        // 3: back-pressure fills the skid, then drains
        load(32'h20, 4);
        step(1'b0, 1'b0, 1'b0);
        chk("t3_adv0", {31'd0, o_fifo_advance}, 32'd1);
        step(1'b0, 1'b0, 1'b0);
        chk("t3_lvl1", {30'd0, o_level}, 32'd1);
        chk("t3_adv1", {31'd0, o_fifo_advance}, 32'd1);
        chk("t3_data1", o_data, 32'h20);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0);
            chk("t3_lvl2", {30'd0, o_level}, 32'd2);
            chk("t3_adv_full", {31'd0, o_fifo_advance}, 32'd0);
            chk("t3_hold", o_data, 32'h20);
        end
        step(1'b1, 1'b0, 1'b0);
        chk("t3_adv_full_rdy", {31'd0, o_fifo_advance}, 32'd0);
        drain(20, 1'b0, 1'b0, "t3_drain");
        chk("t3_cnt", {28'd0, o_cnt}, 32'd12);

        // 4: alternating ready with random empty gaps
        load(32'h40, 20);
        drain(300, 1'b1, 1'b1, "t4_drain");
        chk("t4_cnt", {28'd0, o_cnt}, 32'd0);

        // 5: counter wrap and clear-with-take priority
        load(32'h60, 17);
        drain(100, 1'b0, 1'b0, "t5_drain");
        chk("t5_wrap", {28'd0, o_cnt}, 32'd1);
        load(32'h80, 2);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        chk("t5_take_clr", {31'd0, o_valid}, 32'd1);
        chk("t5_cnt_pre", {28'd0, o_cnt}, 32'd1);
        step(1'b1, 1'b0, 1'b0);
        chk("t5_cnt_clr", {28'd0, o_cnt}, 32'd0);
        chk("t5_data", o_data, 32'h81);
        step(1'b1, 1'b0, 1'b0);
        chk("t5_cnt_after", {28'd0, o_cnt}, 32'd1);
        chk("t5_level", {30'd0, o_level}, 32'd0);

        // 6: asynchronous reset with a full skid
        load(32'hA0, 4);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("t6_lvl2", {30'd0, o_level}, 32'd2);
        chk("t6_cnt_pre", {28'd0, o_cnt}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_valid", {31'd0, o_valid}, 32'd0);
        chk("t6_level", {30'd0, o_level}, 32'd0);
        chk("t6_cnt", {28'd0, o_cnt}, 32'd0);
        chk("t6_adv", {31'd0, o_fifo_advance}, 32'd0);
        chk("t6_data", o_data, 32'd0);
        fifo_q.delete();
        exp_q.delete();
        drive_fifo(1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        chk("t6_post_lvl", {30'd0, o_level}, 32'd0);
        load(32'hB0, 2);
        drain(20, 1'b0, 1'b0, "t6_drain");
        chk("t6_post_cnt", {28'd0, o_cnt}, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_align_rd_stream.md
Name: fifo_align_rd_stream

Overview:
- Read-side consumer of the mesochronous FIFO pointer logic, used with unbuffered next-pointer mode.
- Pops words from the FIFO storage through the empty/advance interface.
- Holds them in a 2-entry registered skid buffer and presents them downstream as a valid/ready stream.
- The FIFO advance never depends combinationally on downstream ready; a wrapping delivered-word counter is kept for debug and statistics.

Parameters:
- DATA_W, 32, width of a FIFO word and of o_data.
- CNT_W, 16, width of the delivered-word counter.

Ports:
- clk  in  1  read-side clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_fifo_empty  in  1  registered empty flag from the pointer logic.
- i_fifo_data  in  DATA_W  storage read-port output; holds the current head word whenever i_fifo_empty=0.
- o_fifo_advance  out  1  pop request to the pointer logic (its read-advance input).
- o_valid  out  1  head word valid downstream.
- o_data  out  DATA_W  head word.
- i_ready  in  1  downstream accepts o_data this cycle when o_valid=1.
- i_cnt_clr  in  1  synchronous clear of the delivered counter.
- o_level  out  2  skid occupancy, 0..2.
- o_cnt  out  CNT_W  words delivered (o_valid & i_ready), wrapping.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset: o_valid=0, o_level=0, o_cnt=0, o_data=0, tail register=0, o_fifo_advance=0.
- Storage: head register (drives o_data) plus tail register; level_q in {0,1,2}; o_valid = (level_q!=0).
- pop = o_fifo_advance = ~i_fifo_empty & (level_q!=2). Depends on registers only, never on i_ready.
- take = o_valid & i_ready.
- Transitions by level and event:
  - level 0, pop: head<=i_fifo_data; level 1.
  - level 1, pop & ~take: tail<=i_fifo_data; level 2.
  - level 1, pop & take: head<=i_fifo_data; level 1.
  - level 1, ~pop & take: level 0; head keeps its stale value.
  - level 2, take: head<=tail; level 1. No pop is possible at level 2.
  - Any other case: hold.
- Latency: a word popped in cycle N appears on o_data with o_valid in cycle N+1.
- Throughput: 1 word/cycle sustained with i_ready=1 (steady state level 1, pop and take every cycle).
- Ordering: strict FIFO order; no word is dropped or duplicated.
- o_data is stable while o_valid=1 and i_ready=0.
- Empty: i_fifo_empty=1 means no pop. Already-buffered words still drain.
- Full skid: at level 2, o_fifo_advance=0 regardless of i_ready. The pop resumes the cycle after level drops to 1 (one bubble; accepted).
- Counter: o_cnt increments by 1 on each take, modulo 2^CNT_W, wrapping all-ones to 0.
  - i_cnt_clr has priority: when i_cnt_clr & take, o_cnt<=0.
- Reset mid-operation: buffered words are discarded and all outputs go to reset values immediately (asynchronous).
  - The pointer logic must be reset in the same cycle, otherwise words are lost. This is a system requirement, not checked here.
- o_level = level_q, registered.

Test Plan:
1. Reset release, i_fifo_empty=1 for 5 cycles -> o_fifo_advance=0, o_valid=0, o_level=0, o_cnt=0 throughout.
2. FIFO holds 8 words 0x10..0x17, i_ready=1 constantly -> advance high for 8 cycles; o_data=0x10..0x17 on consecutive cycles starting one cycle after the first advance; o_cnt=8; o_level back to 0.
3. FIFO holds 4 words, i_ready=0 -> exactly 2 pops, o_level=2, o_data=first word held stable. Raise i_ready -> all 4 delivered in order, one bubble cycle allowed.
4. Alternate i_ready 1/0 every cycle over 20 words with random i_fifo_empty gaps -> scoreboard sees all words in order, no duplicates, o_level never exceeds 2, o_fifo_advance never high while i_fifo_empty=1.
5. CNT_W=4, deliver 17 words -> o_cnt wraps 15->0, ends at 1. Pulse i_cnt_clr together with a take -> o_cnt=0.
6. Assert rst_n=0 mid-stream with o_level=2 -> o_valid, o_level, o_cnt and o_fifo_advance drop to 0 immediately, before the next clock edge.
